module_branch_target_buffer: RTL and testbench
==============================================

MODULE_BRANCH_TARGET_BUFFER -- requirements
Module: module_branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries (power of two, 4..64).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pcF_i, input, XLEN, Fetch-stage PC to look up.
REQ-006 SHALL have port hitF_o, output, 1, valid entry with matching tag for pcF_i.
REQ-007 SHALL have port predict_takenF_o, output, 1, predicted taken for pcF_i.
REQ-008 SHALL have port predicted_targetF_o, output, XLEN, next-PC prediction for pcF_i.
REQ-009 SHALL have port WE_BTB_i, input, 1, resolved branch present in Execute; update enable.
REQ-010 SHALL have port pcE_i, input, XLEN, PC of the Execute-stage branch.
REQ-011 SHALL have port takenE_i, input, 1, actual branch outcome.
REQ-012 SHALL have port targetE_i, input, XLEN, actual branch target.
REQ-013 SHALL have port predict_takenE_i, input, 1, prediction made for this branch in Fetch, piped to Execute.
REQ-014 SHALL have port predicted_targetE_i, input, XLEN, target predicted in Fetch, piped to Execute.
REQ-015 SHALL have port mispredictE_o, output, 1, Execute-stage misprediction flag for the hazard unit.

Function
REQ-016 SHALL index with pc[IDX_W+1:2] (IDX_W = log2(ENTRIES)), tag with pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
REQ-017 SHALL store per entry: valid bit, tag, target, 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-018 SHALL compute lookup combinationally from stored state, zero-cycle latency: hitF_o = valid & tag match; predict_takenF_o = hitF_o & counter[1].
REQ-019 SHALL drive predicted_targetF_o = stored target when predict_takenF_o = 1, else pcF_i + 4 (modulo 2^XLEN).
REQ-020 SHALL, on a rising edge with WE_BTB_i = 1 and a hit at pcE_i, increment the counter if takenE_i else decrement it, saturating at 11 and 00.
REQ-021 SHALL, on that hit with takenE_i = 1, overwrite the stored target with targetE_i.
REQ-022 SHALL, on WE_BTB_i = 1 with a miss and takenE_i = 1, allocate: valid = 1, tag and target from Execute, counter = 10, replacing any aliasing entry.
REQ-023 SHALL NOT allocate on a miss with takenE_i = 0; state unchanged.
REQ-024 SHALL leave all state unchanged when WE_BTB_i = 0.
REQ-025 SHALL give lookup the pre-update contents when Fetch and Execute address the same entry in one cycle (no bypass); the update is visible from the next cycle.
REQ-026 SHALL drive mispredictE_o = WE_BTB_i & ((takenE_i != predict_takenE_i) | (takenE_i & predict_takenE_i & (predicted_targetE_i != targetE_i))), combinationally.

Reset
REQ-027 SHALL, while rst_i = 0, asynchronously clear all valid bits, tags, targets and counters to 0, including mid-update.
REQ-028 SHALL, during and after reset, drive hitF_o = 0, predict_takenF_o = 0, predicted_targetF_o = pcF_i + 4; mispredictE_o follows REQ-026.

Structure
REQ-029 SHALL place ENTRIES/XLEN defaults, the 2-bit counter typedef with its four named states, and the saturating counter next-state function in shared package btb_pkg.
REQ-030 SHALL be a single module with no sub-module; storage is flop arrays, not RAM macros.

Verification (ENTRIES=16; index pc[5:2])
REQ-031 SHALL cover: after reset, pcF_i=0x100 -> hitF_o=0, predict_takenF_o=0, predicted_targetF_o=0x104.
REQ-032 SHALL cover: WE=1, pcE=0x100, taken=1, target=0x80, with pcF=0x100 in the same cycle -> hit=0 that cycle; next cycle hit=1, predict=1, target=0x80.
REQ-033 SHALL cover: after REQ-032, taken updates x2 -> counter 11; not-taken x1 -> predict=1; not-taken x2 -> hit=1, predict=0, target=0x104; further not-taken holds 00.
REQ-034 SHALL cover: alias pcE=0x140, taken=1, target=0x200 -> lookup 0x140 hit, target 0x200, lookup 0x100 miss.
REQ-035 SHALL cover: WE=1, taken=1, predict_takenE=1, predicted_targetE=0x80, targetE=0x84 -> mispredictE_o=1; same values with WE=0 -> 0.
REQ-036 SHALL cover: rst_i low between clock edges after allocations -> hitF_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB definitions: default geometry, 2-bit direction counter and its update rule.
// Latency: n/a (types and functions only). Backpressure: n/a.
package btb_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int BTB_XLEN    = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Saturating step toward the resolved outcome.
  function automatic ctr_t ctrNext(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = STRONG_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/module_branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters and Execute-side update.
// Latency: lookup is combinational (0 cycles); updates become visible the cycle after the edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
module module_branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int XLEN    = BTB_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pcF_i,
  output logic            hitF_o,
  output logic            predict_takenF_o,
  output logic [XLEN-1:0] predicted_targetF_o,
  input  logic            WE_BTB_i,
  input  logic [XLEN-1:0] pcE_i,
  input  logic            takenE_i,
  input  logic [XLEN-1:0] targetE_i,
  input  logic            predict_takenE_i,
  input  logic [XLEN-1:0] predicted_targetE_i,
  output logic            mispredictE_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]   tagQ    [ENTRIES];
  logic [XLEN-1:0]    targetQ [ENTRIES];
  ctr_t               ctrQ    [ENTRIES];

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic             hitE;
  logic             unusedPcLowBits;

  assign idxF = pcF_i[IDX_W+1:2];
  assign tagF = pcF_i[XLEN-1:IDX_W+2];
  assign idxE = pcE_i[IDX_W+1:2];
  assign tagE = pcE_i[XLEN-1:IDX_W+2];

  // Byte offset within the instruction word never participates in indexing or tagging.
  assign unusedPcLowBits = ^{pcF_i[1:0], pcE_i[1:0]};

  assign hitF_o              = validQ[idxF] && (tagQ[idxF] == tagF);
  assign predict_takenF_o    = hitF_o && ctrQ[idxF][1];
  assign predicted_targetF_o = predict_takenF_o ? targetQ[idxF] : pcF_i + XLEN'(4);

  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  assign mispredictE_o = WE_BTB_i &&
                         ((takenE_i != predict_takenE_i) ||
                          (takenE_i && predict_takenE_i && (predicted_targetE_i != targetE_i)));

  // Lookup reads the flops directly, so a same-cycle update is only seen after the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      validQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= STRONG_NT;
      end
    end else if (WE_BTB_i) begin
      if (hitE) begin
        ctrQ[idxE] <= ctrNext(ctrQ[idxE], takenE_i);
        if (takenE_i) begin
          targetQ[idxE] <= targetE_i;
        end
      end else if (takenE_i) begin
        validQ[idxE]  <= 1'b1;
        tagQ[idxE]    <= tagE;
        targetQ[idxE] <= targetE_i;
        ctrQ[idxE]    <= WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_module_branch_target_buffer.sv
// Bench for module_branch_target_buffer: directed scenarios plus randomized traffic
// against a table-of-branches reference model.
module tb_module_branch_target_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pcF_i;
  logic        hitF_o;
  logic        predict_takenF_o;
  logic [31:0] predicted_targetF_o;
  logic        WE_BTB_i;
  logic [31:0] pcE_i;
  logic        takenE_i;
  logic [31:0] targetE_i;
  logic        predict_takenE_i;
  logic [31:0] predicted_targetE_i;
  logic        mispredictE_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: one remembered branch per slot, confidence as an integer 0..3.
  bit          mValid [16];
  int unsigned mTag   [16];
  logic [31:0] mTgt   [16];
  int          mConf  [16];

  module_branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .pcF_i               (pcF_i),
    .hitF_o              (hitF_o),
    .predict_takenF_o    (predict_takenF_o),
    .predicted_targetF_o (predicted_targetF_o),
    .WE_BTB_i            (WE_BTB_i),
    .pcE_i               (pcE_i),
    .takenE_i            (takenE_i),
    .targetE_i           (targetE_i),
    .predict_takenE_i    (predict_takenE_i),
    .predicted_targetE_i (predicted_targetE_i),
    .mispredictE_o       (mispredictE_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return pc / 64;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = 0;
      mTgt[i]   = 32'h0;
      mConf[i]  = 0;
    end
  endtask

  task automatic modelLookup(input logic [31:0] pc, output bit h, output bit p, output logic [31:0] t);
    int s;
    s = slotOf(pc);
    h = mValid[s] && (mTag[s] == tagOf(pc));
    p = h && (mConf[s] >= 2);
    t = p ? mTgt[s] : pc + 32'd4;
  endtask

  task automatic modelUpdate(input bit we, input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    int s;
    s = slotOf(pc);
    if (!we) return;
    if (mValid[s] && mTag[s] == tagOf(pc)) begin
      if (taken) begin
        if (mConf[s] < 3) mConf[s]++;
        mTgt[s] = tgt;
      end else if (mConf[s] > 0) begin
        mConf[s]--;
      end
    end else if (taken) begin
      mValid[s] = 1'b1;
      mTag[s]   = tagOf(pc);
      mTgt[s]   = tgt;
      mConf[s]  = 2;
    end
  endtask

  task automatic drive(input bit we, input logic [31:0] pcE, input bit taken,
                       input logic [31:0] tgtE, input logic [31:0] pcF);
    WE_BTB_i            = we;
    pcE_i               = pcE;
    takenE_i            = taken;
    targetE_i           = tgtE;
    pcF_i               = pcF;
    predict_takenE_i    = 1'b0;
    predicted_targetE_i = 32'h0;
  endtask

  // Clock one edge; the model advances with the inputs that were stable across it.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) modelUpdate(WE_BTB_i, pcE_i, takenE_i, targetE_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    modelClear();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (hitF_o !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hitF_o); end
    checks++;
    if (predict_takenF_o !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", predict_takenF_o); end
    checks++;
    if (predicted_targetF_o !== 32'h104) begin failures++; $display("FAIL reset_tgt got=%h exp=00000104", predicted_targetF_o); end
    rst_i = 1'b1;
    #1;
    checks++;
    if (hitF_o !== 1'b0 || predicted_targetF_o !== 32'h104) begin
      failures++; $display("FAIL post_reset_lookup got=%b/%h exp=0/00000104", hitF_o, predicted_targetF_o);
    end
  endtask

  task automatic test_alloc();
    drive(1'b1, 32'h100, 1'b1, 32'h80, 32'h100);
    #1;
    checks++;
    if (hitF_o !== 1'b0) begin failures++; $display("FAIL alloc_same_cycle_hit got=%b exp=0", hitF_o); end
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    #1;
    checks++;
    if ({hitF_o, predict_takenF_o} !== 2'b11 || predicted_targetF_o !== 32'h80) begin
      failures++; $display("FAIL alloc_next_cycle got=%b%b/%h exp=11/00000080", hitF_o, predict_takenF_o, predicted_targetF_o);
    end
  endtask

  task automatic test_counter();
    repeat (2) begin drive(1'b1, 32'h100, 1'b1, 32'h80, 32'h100); tick(); end
    drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h100); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100); #1;
    checks++;
    if ({hitF_o, predict_takenF_o} !== 2'b11 || predicted_targetF_o !== 32'h80) begin
      failures++; $display("FAIL ctr_after_one_nt got=%b%b/%h exp=11/00000080", hitF_o, predict_takenF_o, predicted_targetF_o);
    end
    repeat (2) begin drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h100); tick(); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100); #1;
    checks++;
    if ({hitF_o, predict_takenF_o} !== 2'b10 || predicted_targetF_o !== 32'h104) begin
      failures++; $display("FAIL ctr_strong_nt got=%b%b/%h exp=10/00000104", hitF_o, predict_takenF_o, predicted_targetF_o);
    end
    repeat (3) begin drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h100); tick(); end
    drive(1'b1, 32'h100, 1'b1, 32'h88, 32'h100); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100); #1;
    checks++;
    if ({hitF_o, predict_takenF_o} !== 2'b10) begin
      failures++; $display("FAIL ctr_floor_hold got=%b%b exp=10", hitF_o, predict_takenF_o);
    end
    drive(1'b1, 32'h100, 1'b1, 32'h8C, 32'h100); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100); #1;
    checks++;
    if (predict_takenF_o !== 1'b1 || predicted_targetF_o !== 32'h8C) begin
      failures++; $display("FAIL ctr_target_refresh got=%b/%h exp=1/0000008c", predict_takenF_o, predicted_targetF_o);
    end
  endtask

  task automatic test_alias();
    drive(1'b1, 32'h140, 1'b1, 32'h200, 32'h140); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h140); #1;
    checks++;
    if (hitF_o !== 1'b1 || predicted_targetF_o !== 32'h200) begin
      failures++; $display("FAIL alias_new got=%b/%h exp=1/00000200", hitF_o, predicted_targetF_o);
    end
    pcF_i = 32'h100; #1;
    checks++;
    if (hitF_o !== 1'b0 || predicted_targetF_o !== 32'h104) begin
      failures++; $display("FAIL alias_old got=%b/%h exp=0/00000104", hitF_o, predicted_targetF_o);
    end
    drive(1'b1, 32'h104, 1'b0, 32'h300, 32'h104); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h104); #1;
    checks++;
    if (hitF_o !== 1'b0) begin failures++; $display("FAIL no_alloc_not_taken got=%b exp=0", hitF_o); end
  endtask

  task automatic test_mispredict();
    drive(1'b1, 32'h100, 1'b1, 32'h84, 32'h0);
    predict_takenE_i    = 1'b1;
    predicted_targetE_i = 32'h80;
    #1;
    checks++;
    if (mispredictE_o !== 1'b1) begin failures++; $display("FAIL mispredict_target got=%b exp=1", mispredictE_o); end
    WE_BTB_i = 1'b0;
    #1;
    checks++;
    if (mispredictE_o !== 1'b0) begin failures++; $display("FAIL mispredict_we0 got=%b exp=0", mispredictE_o); end
    WE_BTB_i = 1'b1; targetE_i = 32'h80;
    #1;
    checks++;
    if (mispredictE_o !== 1'b0) begin failures++; $display("FAIL mispredict_correct got=%b exp=0", mispredictE_o); end
    WE_BTB_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit          h, p, mis;
    logic [31:0] t;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 1) == 1,
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      predict_takenE_i    = $urandom_range(0, 1) == 1;
      predicted_targetE_i = ($urandom_range(0, 1) == 1) ? targetE_i : ($urandom & 32'hFFFF_FFFC);
      #1;
      modelLookup(pcF_i, h, p, t);
      mis = WE_BTB_i && ((takenE_i != predict_takenE_i) ||
                         (takenE_i && predict_takenE_i && predicted_targetE_i != targetE_i));
      checks++;
      if (hitF_o !== h || predict_takenF_o !== p || predicted_targetF_o !== t) begin
        failures++;
        $display("FAIL rand_lookup pc=%h got=%b%b/%h exp=%b%b/%h", pcF_i, hitF_o, predict_takenF_o,
                 predicted_targetF_o, h, p, t);
      end
      checks++;
      if (mispredictE_o !== mis) begin failures++; $display("FAIL rand_mispredict got=%b exp=%b", mispredictE_o, mis); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h140, 1'b1, 32'h200, 32'h140); tick();
    drive(1'b1, 32'h140, 1'b1, 32'h240, 32'h140); #1;
    checks++;
    if (hitF_o !== 1'b1) begin failures++; $display("FAIL pre_reset_hit got=%b exp=1", hitF_o); end
    rst_i = 1'b0;
    #1;
    checks++;
    if (hitF_o !== 1'b0 || predict_takenF_o !== 1'b0 || predicted_targetF_o !== 32'h144) begin
      failures++; $display("FAIL async_reset got=%b%b/%h exp=00/00000144", hitF_o, predict_takenF_o, predicted_targetF_o);
    end
    modelClear();
    tick();
    checks++;
    if (hitF_o !== 1'b0) begin failures++; $display("FAIL reset_blocks_update got=%b exp=0", hitF_o); end
    WE_BTB_i = 1'b0;
    rst_i    = 1'b1;
    #1;
    checks++;
    if (hitF_o !== 1'b0 || predicted_targetF_o !== 32'h144) begin
      failures++; $display("FAIL after_async_reset got=%b/%h exp=0/00000144", hitF_o, predicted_targetF_o);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_mispredict();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
